mc_controller: RTL and testbench
================================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Single clock clk; reset is synchronous and active-high.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 Cond  in  4  instruction condition field Instr[31:28].
REQ-005 Op  in  2  Instr[27:26]: 00 data-processing, 01 memory, 10 branch.
REQ-006 Funct  in  6  Instr[25:20]: I, cmd[3:0], S/L.
REQ-007 Rd  in  4  destination register; 15 means PC.
REQ-008 ALUFlags  in  4  {N,Z,C,V} from ALU, current cycle.
REQ-009 PCWrite  out  1  PC register enable.
REQ-010 MemWrite  out  1  data memory write enable.
REQ-011 RegWrite  out  1  register file write enable.
REQ-012 IRWrite  out  1  instruction register enable.
REQ-013 AdrSrc  out  1  memory address select: 0 PC, 1 ALUResult register.
REQ-014 RegSrc  out  2  [0]=(Op==10), [1]=(Op==01).
REQ-015 ALUSrcA  out  1  0 RD1 register, 1 PC.
REQ-016 ALUSrcB  out  2  00 WriteData register, 01 ExtImm, 10 constant 4.
REQ-017 ResultSrc  out  2  00 ALUOut, 01 Data register, 10 ALUResult.
REQ-018 ImmSrc  out  2  equals Op.
REQ-019 ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR.

Function
REQ-020 Moore FSM states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
REQ-021 FETCH: IRWrite=1, PCWrite=1 (unconditional), AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUControl=00; next DECODE.
REQ-022 DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10; next MEMADR if Op=01, EXECR if Op=00 & Funct[5]=0, EXECI if Op=00 & Funct[5]=1, BRANCH if Op=10, FETCH if Op=11.
REQ-023 MEMADR: ALUSrcA=0, ALUSrcB=01, ALUControl=00; next MEMRD if Funct[0]=1, else MEMWR.
REQ-024 MEMRD: AdrSrc=1, ResultSrc=00; next MEMWB. MEMWB: ResultSrc=01, RegWrite=CondExR; next FETCH.
REQ-025 MEMWR: AdrSrc=1, ResultSrc=00, MemWrite=CondExR; next FETCH.
REQ-026 EXECR: ALUSrcA=0, ALUSrcB=00; EXECI: ALUSrcA=0, ALUSrcB=01; both use decoded ALUControl and go to ALUWB.
REQ-027 ALUWB: ResultSrc=00, RegWrite=CondExR & ~NoWrite; PCWrite=CondExR & (Rd==15); next FETCH.
REQ-028 BRANCH: ALUSrcA=0, ALUSrcB=01, ALUControl=00, ResultSrc=10, PCWrite=CondExR; next FETCH.
REQ-029 ALU decode on cmd=Funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR; any other cmd: ALUControl=00, no register or flag write.
REQ-030 FlagW[1] (N,Z) = S; FlagW[0] (C,V) = S & (ADD|SUB); Flags register updates from ALUFlags only in EXECR/EXECI when CondExR=1.
REQ-031 CondEx computed in DECODE from Cond and stored Flags (EQ..LE standard ARM, 1110 AL=1, 1111=0), latched into CondExR at DECODE exit.
REQ-032 Latency: LDR 5 cycles, STR 4, data-processing 4, branch 3, Op=11 2.
REQ-033 All unlisted outputs 0 in each state.

Reset
REQ-034 While reset=1: next state FETCH, Flags=0000, CondExR=0, and PCWrite/IRWrite/RegWrite/MemWrite forced 0; reset mid-instruction abandons it with no write.

Configuration
REQ-035 Macro MC_CMP_EN defined: cmd 1010 decodes as SUB with FlagW=11 and NoWrite=1 (flags only); undefined: cmd 1010 is unsupported per REQ-029.

Verification
REQ-036 Reset, then Op=00 Funct=001000 Cond=1110 -> FETCH,DECODE,EXECR,ALUWB; RegWrite=1 only in cycle 4, ALUControl=00.
REQ-037 Op=01 Funct=011001 Cond=1110 -> 5 cycles; AdrSrc=1 in MEMRD, RegWrite=1 in MEMWB.
REQ-038 Flags Z=0, Op=01 Funct=011000 Cond=0000 -> MEMWR reached, MemWrite stays 0, back to FETCH after 4 cycles.
REQ-039 SUBS (Funct=000101) with ALUFlags=0100, then branch Op=10 Cond=0000 -> Flags=0100, PCWrite=1 in BRANCH.
REQ-040 Funct=010101 with ALUFlags=0100: MC_CMP_EN on -> Flags=0100, RegWrite 0; off -> Flags unchanged, RegWrite 0.
REQ-041 reset=1 during MEMWR -> MemWrite=0 that cycle, state FETCH next cycle.

Source files
------------

// File: rtl/mc_controller.sv
// Multicycle processor control unit: Moore sequencing FSM, ALU/flag decode and conditional execution.
// Build option: define MC_CMP_EN to decode cmd 1010 as a flags-only compare (SUB, no register write).
module mc_controller (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] Cond,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic [3:0] Rd,
   input  logic [3:0] ALUFlags,
   output logic       PCWrite,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic       IRWrite,
   output logic       AdrSrc,
   output logic [1:0] RegSrc,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic [1:0] ImmSrc,
   output logic [1:0] ALUControl
);

   // state  | meaning
   // FETCH  | read instruction at PC, PC <= PC+4
   // DECODE | read registers, evaluate condition
   // MEMADR | compute load/store address
   // MEMRD  | read data memory
   // MEMWB  | write loaded data to register file
   // MEMWR  | write data memory
   // EXECR  | ALU op with register operand
   // EXECI  | ALU op with immediate operand
   // ALUWB  | write ALU result (PC if Rd==15)
   // BRANCH | load branch target into PC
   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
   } state_t;

`ifdef MC_CMP_EN
   localparam logic CmpEn = 1'b1;
`else
   localparam logic CmpEn = 1'b0;
`endif

   state_t     state, nextState;
   logic [3:0] flags;
   logic       condEx, condExR;
   logic [1:0] decAluCtl;
   logic [1:0] flagW;
   logic       noWrite;
   logic       flagN, flagZ, flagC, flagV;

   assign {flagN, flagZ, flagC, flagV} = flags;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= FETCH;
         flags   <= 4'b0000;
         condExR <= 1'b0;
      end else begin
         state <= nextState;
         if (state == DECODE)
            condExR <= condEx;
         if ((state == EXECR || state == EXECI) && condExR) begin
            if (flagW[1]) flags[3:2] <= ALUFlags[3:2];
            if (flagW[0]) flags[1:0] <= ALUFlags[1:0];
         end
      end
   end

   always_comb begin
      condEx = 1'b0;
      case (Cond)
         4'b0000: condEx = flagZ;
         4'b0001: condEx = ~flagZ;
         4'b0010: condEx = flagC;
         4'b0011: condEx = ~flagC;
         4'b0100: condEx = flagN;
         4'b0101: condEx = ~flagN;
         4'b0110: condEx = flagV;
         4'b0111: condEx = ~flagV;
         4'b1000: condEx = flagC & ~flagZ;
         4'b1001: condEx = ~flagC | flagZ;
         4'b1010: condEx = (flagN == flagV);
         4'b1011: condEx = (flagN != flagV);
         4'b1100: condEx = ~flagZ & (flagN == flagV);
         4'b1101: condEx = flagZ | (flagN != flagV);
         4'b1110: condEx = 1'b1;
         default: condEx = 1'b0;
      endcase
   end

   // Unsupported commands fall through with ADD control and no register or flag write.
   always_comb begin
      decAluCtl = 2'b00;
      flagW     = 2'b00;
      noWrite   = 1'b1;
      case (Funct[4:1])
         4'b0100: begin decAluCtl = 2'b00; noWrite = 1'b0; flagW = {Funct[0], Funct[0]}; end
         4'b0010: begin decAluCtl = 2'b01; noWrite = 1'b0; flagW = {Funct[0], Funct[0]}; end
         4'b0000: begin decAluCtl = 2'b10; noWrite = 1'b0; flagW = {Funct[0], 1'b0}; end
         4'b1100: begin decAluCtl = 2'b11; noWrite = 1'b0; flagW = {Funct[0], 1'b0}; end
         4'b1010: begin
            if (CmpEn) begin
               decAluCtl = 2'b01;
               flagW     = 2'b11;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      nextState  = FETCH;
      PCWrite    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      IRWrite    = 1'b0;
      AdrSrc     = 1'b0;
      RegSrc     = {(Op == 2'b01), (Op == 2'b10)};
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ResultSrc  = 2'b00;
      ImmSrc     = Op;
      ALUControl = 2'b00;
      case (state)
         FETCH: begin
            IRWrite   = 1'b1;
            PCWrite   = 1'b1;
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            nextState = DECODE;
         end
         DECODE: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            case (Op)
               2'b00:   nextState = Funct[5] ? EXECI : EXECR;
               2'b01:   nextState = MEMADR;
               2'b10:   nextState = BRANCH;
               default: nextState = FETCH;
            endcase
         end
         MEMADR: begin
            ALUSrcB   = 2'b01;
            nextState = Funct[0] ? MEMRD : MEMWR;
         end
         MEMRD: begin
            AdrSrc    = 1'b1;
            nextState = MEMWB;
         end
         MEMWB: begin
            ResultSrc = 2'b01;
            RegWrite  = condExR;
         end
         MEMWR: begin
            AdrSrc   = 1'b1;
            MemWrite = condExR;
         end
         EXECR: begin
            ALUControl = decAluCtl;
            nextState  = ALUWB;
         end
         EXECI: begin
            ALUSrcB    = 2'b01;
            ALUControl = decAluCtl;
            nextState  = ALUWB;
         end
         ALUWB: begin
            RegWrite = condExR & ~noWrite;
            PCWrite  = condExR & (Rd == 4'd15);
         end
         BRANCH: begin
            ALUSrcB   = 2'b01;
            ResultSrc = 2'b10;
            PCWrite   = condExR;
         end
         default: nextState = FETCH;
      endcase
      if (reset) begin
         PCWrite  = 1'b0;
         IRWrite  = 1'b0;
         RegWrite = 1'b0;
         MemWrite = 1'b0;
      end
   end

endmodule

// File: tb/tb_mc_controller.sv
// Directed per-cycle vector bench for mc_controller; flags are observed through conditional branches.
module tb_mc_controller;

   logic       clk, reset;
   logic [3:0] Cond, Rd, ALUFlags;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
   logic [1:0] RegSrc, ALUSrcB, ResultSrc, ImmSrc, ALUControl;

   mc_controller dut (
      .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
      .ALUFlags(ALUFlags), .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
      .IRWrite(IRWrite), .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam int F = 0, D = 1, MA = 2, MR = 3, MB = 4, MW = 5, ER = 6, EI = 7, AW = 8, BR = 9;

   typedef struct {
      logic        rst;
      logic [3:0]  cond;
      logic [1:0]  op;
      logic [5:0]  funct;
      logic [3:0]  rd;
      logic [3:0]  flg;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[$];
   int   nChecks = 0;
   int   nPass   = 0;

   // Expected bus: {PCWrite,MemWrite,RegWrite,IRWrite,AdrSrc,RegSrc,ALUSrcA,ALUSrcB,ResultSrc,ImmSrc,ALUControl}
   function automatic logic [15:0] e(int st, logic [1:0] op, logic [1:0] aluc, logic [3:0] wr);
      logic       adr, a;
      logic [1:0] b, r;
      adr = 1'b0; a = 1'b0; b = 2'b00; r = 2'b00;
      case (st)
         F:  begin a = 1'b1; b = 2'b10; r = 2'b10; end
         D:  begin a = 1'b1; b = 2'b10; r = 2'b10; end
         MA: b = 2'b01;
         MR: adr = 1'b1;
         MB: r = 2'b01;
         MW: adr = 1'b1;
         EI: b = 2'b01;
         BR: begin b = 2'b01; r = 2'b10; end
         default: ;
      endcase
      return {wr, adr, (op == 2'b01), (op == 2'b10), a, b, r, op, aluc};
   endfunction

   function automatic void add(logic rst, logic [3:0] cond, logic [1:0] op, logic [5:0] funct,
                               logic [3:0] rd, logic [3:0] flg, logic [15:0] exp);
      vec_t v;
      v.rst = rst; v.cond = cond; v.op = op; v.funct = funct; v.rd = rd; v.flg = flg; v.exp = exp;
      vecs.push_back(v);
   endfunction

   task automatic step(string nm, vec_t v);
      logic [15:0] got;
      @(negedge clk);
      reset = v.rst; Cond = v.cond; Op = v.op; Funct = v.funct; Rd = v.rd; ALUFlags = v.flg;
      #1;
      got = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA, ALUSrcB,
             ResultSrc, ImmSrc, ALUControl};
      nChecks++;
      if (got === v.exp) nPass++;
      else $display("FAIL %s: outputs got %b want %b", nm, got, v.exp);
   endtask

   task automatic hand(string nm, logic rst, logic [3:0] cond, logic [1:0] op, logic [5:0] funct,
                       logic [3:0] rd, logic [3:0] flg, logic [15:0] exp);
      vec_t v;
      v.rst = rst; v.cond = cond; v.op = op; v.funct = funct; v.rd = rd; v.flg = flg; v.exp = exp;
      step(nm, v);
   endtask

   localparam logic [3:0] AL = 4'b1110, EQ = 4'b0000, NE = 4'b0001;
   localparam logic [5:0] ADDR = 6'b001000, LDR = 6'b011001, STR = 6'b011000, SUBS = 6'b000101;
   localparam logic [5:0] ADDS = 6'b001001, CMPS = 6'b010101, ORRI = 6'b111000, EORS = 6'b000011;

`ifdef MC_CMP_EN
   localparam logic [1:0] CmpAlu = 2'b01;
   localparam logic [3:0] CmpBrWr = 4'b1000;
`else
   localparam logic [1:0] CmpAlu = 2'b00;
   localparam logic [3:0] CmpBrWr = 4'b0000;
`endif

   initial begin
      reset = 1'b1; Cond = AL; Op = 2'b00; Funct = ADDR; Rd = 4'd0; ALUFlags = 4'b0000;
      repeat (2) @(posedge clk);

      add(1, AL, 2'b00, ADDR, 0, 0, e(F, 2'b00, 2'b00, 4'b0000));
      // ADD register form
      add(0, AL, 2'b00, ADDR, 0, 0, e(F,  2'b00, 2'b00, 4'b1001));
      add(0, AL, 2'b00, ADDR, 0, 0, e(D,  2'b00, 2'b00, 4'b0000));
      add(0, AL, 2'b00, ADDR, 0, 0, e(ER, 2'b00, 2'b00, 4'b0000));
      add(0, AL, 2'b00, ADDR, 0, 0, e(AW, 2'b00, 2'b00, 4'b0010));
      // LDR
      add(0, AL, 2'b01, LDR, 1, 0, e(F,  2'b01, 2'b00, 4'b1001));
      add(0, AL, 2'b01, LDR, 1, 0, e(D,  2'b01, 2'b00, 4'b0000));
      add(0, AL, 2'b01, LDR, 1, 0, e(MA, 2'b01, 2'b00, 4'b0000));
      add(0, AL, 2'b01, LDR, 1, 0, e(MR, 2'b01, 2'b00, 4'b0000));
      add(0, AL, 2'b01, LDR, 1, 0, e(MB, 2'b01, 2'b00, 4'b0010));
      // STREQ with Z=0: suppressed
      add(0, EQ, 2'b01, STR, 2, 0, e(F,  2'b01, 2'b00, 4'b1001));
      add(0, EQ, 2'b01, STR, 2, 0, e(D,  2'b01, 2'b00, 4'b0000));
      add(0, EQ, 2'b01, STR, 2, 0, e(MA, 2'b01, 2'b00, 4'b0000));
      add(0, EQ, 2'b01, STR, 2, 0, e(MW, 2'b01, 2'b00, 4'b0000));
      // SUBS sets Z
      add(0, AL, 2'b00, SUBS, 3, 4'b0000, e(F,  2'b00, 2'b00, 4'b1001));
      add(0, AL, 2'b00, SUBS, 3, 4'b0000, e(D,  2'b00, 2'b00, 4'b0000));
      add(0, AL, 2'b00, SUBS, 3, 4'b0100, e(ER, 2'b00, 2'b01, 4'b0000));
      add(0, AL, 2'b00, SUBS, 3, 4'b0000, e(AW, 2'b00, 2'b00, 4'b0010));
      // BEQ taken, BNE not taken
      add(0, EQ, 2'b10, 6'b0, 0, 0, e(F,  2'b10, 2'b00, 4'b1001));
      add(0, EQ, 2'b10, 6'b0, 0, 0, e(D,  2'b10, 2'b00, 4'b0000));
      add(0, EQ, 2'b10, 6'b0, 0, 0, e(BR, 2'b10, 2'b00, 4'b1000));
      add(0, NE, 2'b10, 6'b0, 0, 0, e(F,  2'b10, 2'b00, 4'b1001));
      add(0, NE, 2'b10, 6'b0, 0, 0, e(D,  2'b10, 2'b00, 4'b0000));
      add(0, NE, 2'b10, 6'b0, 0, 0, e(BR, 2'b10, 2'b00, 4'b0000));
      // ADDS clears Z
      add(0, AL, 2'b00, ADDS, 4, 4'b0000, e(F,  2'b00, 2'b00, 4'b1001));
      add(0, AL, 2'b00, ADDS, 4, 4'b0000, e(D,  2'b00, 2'b00, 4'b0000));
      add(0, AL, 2'b00, ADDS, 4, 4'b0000, e(ER, 2'b00, 2'b00, 4'b0000));
      add(0, AL, 2'b00, ADDS, 4, 4'b0000, e(AW, 2'b00, 2'b00, 4'b0010));
      // cmd 1010: flags-only compare when enabled, ignored otherwise
      add(0, AL, 2'b00, CMPS, 5, 4'b0000, e(F,  2'b00, 2'b00, 4'b1001));
      add(0, AL, 2'b00, CMPS, 5, 4'b0000, e(D,  2'b00, 2'b00, 4'b0000));
      add(0, AL, 2'b00, CMPS, 5, 4'b0100, e(ER, 2'b00, CmpAlu, 4'b0000));
      add(0, AL, 2'b00, CMPS, 5, 4'b0000, e(AW, 2'b00, 2'b00, 4'b0000));
      add(0, EQ, 2'b10, 6'b0, 0, 0, e(F,  2'b10, 2'b00, 4'b1001));
      add(0, EQ, 2'b10, 6'b0, 0, 0, e(D,  2'b10, 2'b00, 4'b0000));
      add(0, EQ, 2'b10, 6'b0, 0, 0, e(BR, 2'b10, 2'b00, CmpBrWr));
      // ORR immediate to PC
      add(0, AL, 2'b00, ORRI, 15, 0, e(F,  2'b00, 2'b00, 4'b1001));
      add(0, AL, 2'b00, ORRI, 15, 0, e(D,  2'b00, 2'b00, 4'b0000));
      add(0, AL, 2'b00, ORRI, 15, 0, e(EI, 2'b00, 2'b11, 4'b0000));
      add(0, AL, 2'b00, ORRI, 15, 0, e(AW, 2'b00, 2'b00, 4'b1010));
      // Op=11 returns to FETCH after DECODE
      add(0, AL, 2'b11, 6'b0, 0, 0, e(F, 2'b11, 2'b00, 4'b1001));
      add(0, AL, 2'b11, 6'b0, 0, 0, e(D, 2'b11, 2'b00, 4'b0000));
      // unsupported cmd 0001: no write
      add(0, AL, 2'b00, EORS, 6, 4'b0000, e(F,  2'b00, 2'b00, 4'b1001));
      add(0, AL, 2'b00, EORS, 6, 4'b0000, e(D,  2'b00, 2'b00, 4'b0000));
      add(0, AL, 2'b00, EORS, 6, 4'b1111, e(ER, 2'b00, 2'b00, 4'b0000));
      add(0, AL, 2'b00, EORS, 6, 4'b0000, e(AW, 2'b00, 2'b00, 4'b0000));
      // STR always
      add(0, AL, 2'b01, STR, 7, 0, e(F,  2'b01, 2'b00, 4'b1001));
      add(0, AL, 2'b01, STR, 7, 0, e(D,  2'b01, 2'b00, 4'b0000));
      add(0, AL, 2'b01, STR, 7, 0, e(MA, 2'b01, 2'b00, 4'b0000));
      add(0, AL, 2'b01, STR, 7, 0, e(MW, 2'b01, 2'b00, 4'b0100));

      for (int i = 0; i < vecs.size(); i++)
         step($sformatf("vec%0d", i), vecs[i]);

      // Reset during MEMWR: no write, back to FETCH, flags cleared
      hand("rs_subs_f", 0, AL, 2'b00, SUBS, 3, 4'b0000, e(F,  2'b00, 2'b00, 4'b1001));
      hand("rs_subs_d", 0, AL, 2'b00, SUBS, 3, 4'b0000, e(D,  2'b00, 2'b00, 4'b0000));
      hand("rs_subs_e", 0, AL, 2'b00, SUBS, 3, 4'b0100, e(ER, 2'b00, 2'b01, 4'b0000));
      hand("rs_subs_w", 0, AL, 2'b00, SUBS, 3, 4'b0000, e(AW, 2'b00, 2'b00, 4'b0010));
      hand("rs_str_f",  0, AL, 2'b01, STR, 7, 0, e(F,  2'b01, 2'b00, 4'b1001));
      hand("rs_str_d",  0, AL, 2'b01, STR, 7, 0, e(D,  2'b01, 2'b00, 4'b0000));
      hand("rs_str_ma", 0, AL, 2'b01, STR, 7, 0, e(MA, 2'b01, 2'b00, 4'b0000));
      hand("rs_str_mw", 1, AL, 2'b01, STR, 7, 0, e(MW, 2'b01, 2'b00, 4'b0000));
      hand("rs_fetch",  0, EQ, 2'b10, 6'b0, 0, 0, e(F,  2'b10, 2'b00, 4'b1001));
      hand("rs_beq_d",  0, EQ, 2'b10, 6'b0, 0, 0, e(D,  2'b10, 2'b00, 4'b0000));
      hand("rs_beq_br", 0, EQ, 2'b10, 6'b0, 0, 0, e(BR, 2'b10, 2'b00, 4'b0000));
      hand("rs_next",   0, AL, 2'b00, ADDR, 0, 0, e(F,  2'b00, 2'b00, 4'b1001));

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
